// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key search slice.
//   DefaultKeyWidth : default RC4 secret key width
//   MsgLen          : decrypted message length in bytes
//   RamAddrWidth    : address width of the decrypted message RAM
//   state_e         : key search controller FSM states
//   ram_owner_e     : which block currently owns the message RAM port
package rc4_pkg;

  localparam int unsigned DefaultKeyWidth = 24;
  localparam int unsigned MsgLen          = 32;
  localparam int unsigned RamAddrWidth    = $clog2(MsgLen);
  localparam int unsigned RamDataWidth    = 8;

  typedef enum logic [3:0] {
    StIdle,
    StLoadKey,
    StSubReset,
    StRunCore,
    StRunCheck,
    StEval,
    StNextKey,
    StFound,
    StFail
  } state_e;

  typedef enum logic [1:0] {
    OwnNone = 2'b00,
    OwnCore = 2'b01,
    OwnChk  = 2'b10
  } ram_owner_e;

endpackage

// File: rtl/msg_ram_arbiter.sv
// Multiplexes the decrypted message RAM port between the decrypt core and the
// valid-key checker.
//   clk, reset_n        : clock, asynchronous active-low reset
//   owner               : current port owner (none / core / checker)
//   core_addr/wren/data : decrypt core side
//   chk_addr/wren       : checker side (checker is read-only, writes suppressed)
//   ram_addr/wren/data  : muxed RAM port; address holds while nobody owns it
module msg_ram_arbiter
  import rc4_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  ram_owner_e              owner,
  input  logic [RamAddrWidth-1:0] core_addr,
  input  logic                    core_wren,
  input  logic [RamDataWidth-1:0] core_data,
  input  logic [RamAddrWidth-1:0] chk_addr,
  input  logic                    chk_wren,
  output logic [RamAddrWidth-1:0] ram_addr,
  output logic                    ram_wren,
  output logic [RamDataWidth-1:0] ram_data
);

  logic [RamAddrWidth-1:0] addr_q;
  logic                    unused_chk_wren;

  // The checker only reads the message, so its write enable is ignored.
  assign unused_chk_wren = chk_wren;

  always_comb begin
    ram_addr = addr_q;
    ram_wren = 1'b0;
    unique case (owner)
      OwnCore: begin
        ram_addr = core_addr;
        ram_wren = core_wren;
      end
      OwnChk:  ram_addr = chk_addr;
      default: ;
    endcase
  end

  // Data only matters while the core owns the port (wren is 0 otherwise).
  assign ram_data = core_data;

  // Remember the last driven address so it holds between owners.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= ram_addr;
    end
  end

endmodule

// File: rtl/key_search_controller.sv
// Brute-force RC4 key search controller. Steps secret_key through
// KEY_FIRST..KEY_LAST, running the decrypt core then the valid-key checker for
// each key, and stops on the first key the checker accepts.
//   clk, reset_n               : clock, asynchronous active-low reset
//   start                      : level; search runs while high, drop to abort/clear
//   secret_key                 : key presented to the decrypt core
//   core_reset/start/done      : decrypt core handshake
//   chk_reset/start/done/valid : valid-key checker handshake
//   core_*/chk_* RAM inputs    : RAM port requests from core and checker
//   ram_addr/wren/data         : muxed decrypted message RAM port
//   found/failed/busy          : search status
// Optional build macro KEY_COUNT_EN adds output keys_tried (keys evaluated).
module key_search_controller
  import rc4_pkg::*;
#(
  parameter int unsigned          KEY_WIDTH = DefaultKeyWidth,
  parameter logic [KEY_WIDTH-1:0] KEY_FIRST = '0,
  parameter logic [KEY_WIDTH-1:0] KEY_LAST  = KEY_WIDTH'(24'h3FFFFF)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  output logic [KEY_WIDTH-1:0]    secret_key,
  output logic                    core_reset,
  output logic                    core_start,
  input  logic                    core_done,
  output logic                    chk_reset,
  output logic                    chk_start,
  input  logic                    chk_done,
  input  logic                    chk_valid,
  input  logic [RamAddrWidth-1:0] core_addr,
  input  logic                    core_wren,
  input  logic [RamDataWidth-1:0] core_data,
  input  logic [RamAddrWidth-1:0] chk_addr,
  input  logic                    chk_wren,
  output logic [RamAddrWidth-1:0] ram_addr,
  output logic                    ram_wren,
  output logic [RamDataWidth-1:0] ram_data,
  output logic                    found,
  output logic                    failed,
  output logic                    busy
`ifdef KEY_COUNT_EN
  ,
  output logic [KEY_WIDTH-1:0]    keys_tried
`endif
);

  state_e               state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic                 sub_reset_q, sub_reset_d;
  logic                 abort;
  ram_owner_e           owner;

  assign busy = !(state_q inside {StIdle, StFound, StFail});

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    abort   = 1'b0;
    unique case (state_q)
      StIdle:     if (start) state_d = StLoadKey;
      StLoadKey: begin
        key_d   = KEY_FIRST;
        state_d = StSubReset;
      end
      StSubReset: state_d = StRunCore;
      StRunCore:  if (core_done) state_d = StRunCheck;
      StRunCheck: if (chk_done) state_d = StEval;
      StEval: begin
        if (chk_valid)             state_d = StFound;
        else if (key_q == KEY_LAST) state_d = StFail;
        else                       state_d = StNextKey;
      end
      StNextKey: begin
        if (key_q != KEY_LAST) key_d = key_q + KEY_WIDTH'(1);
        state_d = StSubReset;
      end
      StFound, StFail: if (!start) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
    // Losing start mid-search wins over every other transition.
    if (busy && !start) begin
      abort   = 1'b1;
      state_d = StIdle;
    end
  end

  // Sub-block resets are registered so they sit high through reset and fall
  // on the first clock edge; they pulse for the cycle spent in SUB_RESET and
  // for the first IDLE cycle after an abort.
  assign sub_reset_d = (state_d == StSubReset) || abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      key_q       <= KEY_FIRST;
      sub_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      sub_reset_q <= sub_reset_d;
    end
  end

  assign secret_key = key_q;
  assign core_reset = sub_reset_q;
  assign chk_reset  = sub_reset_q;
  assign core_start = (state_q == StRunCore);
  assign chk_start  = (state_q == StRunCheck);
  assign found      = (state_q == StFound);
  assign failed     = (state_q == StFail);

  always_comb begin
    owner = OwnNone;
    if (state_q == StRunCore)  owner = OwnCore;
    if (state_q == StRunCheck) owner = OwnChk;
  end

  msg_ram_arbiter u_arbiter (
    .clk       (clk),
    .reset_n   (reset_n),
    .owner     (owner),
    .core_addr (core_addr),
    .core_wren (core_wren),
    .core_data (core_data),
    .chk_addr  (chk_addr),
    .chk_wren  (chk_wren),
    .ram_addr  (ram_addr),
    .ram_wren  (ram_wren),
    .ram_data  (ram_data)
  );

`ifdef KEY_COUNT_EN
  logic [KEY_WIDTH-1:0] tried_q, tried_d;

  always_comb begin
    tried_d = tried_q;
    if (state_q == StLoadKey)   tried_d = '0;
    else if (state_q == StEval) tried_d = tried_q + KEY_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tried_q <= '0;
    else          tried_q <= tried_d;
  end

  assign keys_tried = tried_q;
`else
  // No key counter in this build.
`endif

endmodule
